// File: rtl/calc_pkg.sv
// Width helpers shared by the display command decoders: address and
// select-field widths derived from panel geometry.
package calc_pkg;

    // Never return 0 so that degenerate geometries still get a 1-bit field.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned num_row_address_bits(input int unsigned pixel_height);
        return clog2_min1(pixel_height);
    endfunction

    function automatic int unsigned num_column_address_bits(input int unsigned pixel_width);
        return clog2_min1(pixel_width);
    endfunction

    function automatic int unsigned num_pixelcolorselect_bits(input int unsigned bytes_per_pixel);
        return clog2_min1(bytes_per_pixel);
    endfunction

    function automatic int unsigned num_bytes_to_contain(input int unsigned bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/commands_pkg.sv
// Opcodes of the serial command dispatcher and the state types of the
// per-command sub-decoders.
package commands_pkg;

    typedef enum logic [7:0] {
        CMD_NOP       = 8'h00,
        CMD_READ_ROW  = 8'h01,
        CMD_WRITE_ROW = 8'h02,
        CMD_FILL      = 8'h03
    } cmd_opcode_t;

    typedef enum logic [0:0] {
        CAPTURE_ROW = 1'b0,
        DATA        = 1'b1
    } readrow_state_t;

endpackage

// File: rtl/readrow_addr_counter.sv
// Down-counting column/pixel pair for the read-row decoder; presents the
// address of the next byte to be written and flags the final (0,0) slot.
module readrow_addr_counter
    import calc_pkg::*;
#(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int PIXEL_WIDTH     = 64,
    localparam int CB = num_column_address_bits(PIXEL_WIDTH),
    localparam int PB = num_pixelcolorselect_bits(BYTES_PER_PIXEL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          step_i,
    output logic [CB-1:0] column_o,
    output logic [PB-1:0] pixel_o,
    output logic          last_o
);

    localparam logic [CB-1:0] COL_MAX = CB'(PIXEL_WIDTH - 1);
    localparam logic [PB-1:0] PIX_MAX = PB'(BYTES_PER_PIXEL - 1);

    logic [CB-1:0] col_q, col_d;
    logic [PB-1:0] pix_q, pix_d;

    always_comb begin
        col_d = col_q;
        pix_d = pix_q;
        if (load_i) begin
            col_d = COL_MAX;
            pix_d = PIX_MAX;
        end else if (step_i) begin
            // Pixel byte select wraps and borrows one column.
            if (pix_q == '0) begin
                pix_d = PIX_MAX;
                col_d = col_q - 1'b1;
            end else begin
                pix_d = pix_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            pix_q <= '0;
        end else begin
            col_q <= col_d;
            pix_q <= pix_d;
        end
    end

    assign column_o = col_q;
    assign pixel_o  = pix_q;
    assign last_o   = (col_q == '0) && (pix_q == '0);

endmodule

// File: rtl/control_cmd_read_row.sv
// "Read row" command sub-decoder: row-select byte, then one full row of pixel
// bytes turned into frame-RAM writes. Optional stall abort: CMD_READROW_TIMEOUT_EN.
module control_cmd_read_row
    import calc_pkg::*;
    import commands_pkg::*;
#(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int PIXEL_HEIGHT    = 32,
    parameter int PIXEL_WIDTH     = 64,
    parameter int _UNUSED         = 0,
`ifdef CMD_READROW_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES  = 4096,
`endif
    localparam int RB = num_row_address_bits(PIXEL_HEIGHT),
    localparam int CB = num_column_address_bits(PIXEL_WIDTH),
    localparam int PB = num_pixelcolorselect_bits(BYTES_PER_PIXEL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [7:0]    data_in,
    output logic [RB-1:0] row,
    output logic [CB-1:0] column,
    output logic [PB-1:0] pixel,
    output logic [7:0]    data_out,
    output logic          ram_write_enable,
    output logic          ram_access_start,
    output logic          done
);

    if (_UNUSED != 0) begin : g_unused_placeholder
    end

    readrow_state_t state_q, state_d;
    logic [RB-1:0]  row_q, row_d;
    logic [CB-1:0]  column_q, column_d;
    logic [PB-1:0]  pixel_q, pixel_d;
    logic [7:0]     data_q, data_d;
    logic           we_q, we_d;
    logic           ras_q, ras_d;
    logic           done_q, done_d;

    logic           cnt_load, cnt_step, cnt_last;
    logic [CB-1:0]  cnt_column;
    logic [PB-1:0]  cnt_pixel;
    logic           timeout;

    readrow_addr_counter #(
        .BYTES_PER_PIXEL (BYTES_PER_PIXEL),
        .PIXEL_WIDTH     (PIXEL_WIDTH)
    ) u_addr (
        .clk      (clk),
        .reset    (reset),
        .load_i   (cnt_load),
        .step_i   (cnt_step),
        .column_o (cnt_column),
        .pixel_o  (cnt_pixel),
        .last_o   (cnt_last)
    );

`ifdef CMD_READROW_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_q, idle_d;

    always_comb begin
        idle_d = '0;
        if ((state_q == DATA) && !enable)
            idle_d = idle_q + 1'b1;
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive idle clock spent in DATA.
    assign timeout = (state_q == DATA) && !enable && (idle_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            idle_q <= '0;
        else
            idle_q <= idle_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        column_d = column_q;
        pixel_d  = pixel_q;
        data_d   = data_q;
        we_d     = we_q;
        ras_d    = ras_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_step = 1'b0;

        // The clock after done retires the final write even if a new row byte lands.
        if (done_q) begin
            data_d = '0;
            we_d   = 1'b0;
        end

        case (state_q)
            CAPTURE_ROW: begin
                if (enable) begin
                    row_d    = data_in[RB-1:0];
                    data_d   = '0;
                    we_d     = 1'b0;
                    cnt_load = 1'b1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (enable) begin
                    data_d   = data_in;
                    we_d     = 1'b1;
                    column_d = cnt_column;
                    pixel_d  = cnt_pixel;
                    ras_d    = ~ras_q;
                    cnt_step = 1'b1;
                    if (cnt_last) begin
                        done_d  = 1'b1;
                        state_d = CAPTURE_ROW;
                    end
                end else if (timeout) begin
                    data_d   = '0;
                    we_d     = 1'b0;
                    cnt_load = 1'b1;
                    state_d  = CAPTURE_ROW;
                end
            end
            default: state_d = CAPTURE_ROW;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= CAPTURE_ROW;
            row_q    <= '0;
            column_q <= '0;
            pixel_q  <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            ras_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            column_q <= column_d;
            pixel_q  <= pixel_d;
            data_q   <= data_d;
            we_q     <= we_d;
            ras_q    <= ras_d;
            done_q   <= done_d;
        end
    end

    assign row              = row_q;
    assign column           = column_q;
    assign pixel            = pixel_q;
    assign data_out         = data_q;
    assign ram_write_enable = we_q;
    assign ram_access_start = ras_q;
    assign done             = done_q;

endmodule

// File: tb/tb_control_cmd_read_row.sv
// Randomized self-checking bench for control_cmd_read_row; expected RAM writes
// come from a row/byte-index model of the command stream.
module tb_control_cmd_read_row;

    localparam int BPP   = 2;
    localparam int PH    = 32;
    localparam int PW    = 64;
    localparam int NDATA = PW * BPP;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [4:0] row;
    logic [5:0] column;
    logic [0:0] pixel;
    logic [7:0] data_out;
    logic       ram_write_enable;
    logic       ram_access_start;
    logic       done;

    int checks = 0;
    int failures = 0;

    logic [4:0] exp_row  = '0;
    logic [5:0] exp_col  = '0;
    logic [0:0] exp_pix  = '0;
    logic [7:0] exp_data = '0;
    logic       exp_we   = 1'b0;
    logic       exp_ras  = 1'b0;

    int   toggle_cnt = 0;
    int   done_cnt = 0;
    logic ras_prev = 1'b0;

    control_cmd_read_row #(
        .BYTES_PER_PIXEL (BPP),
        .PIXEL_HEIGHT    (PH),
        .PIXEL_WIDTH     (PW),
        ._UNUSED         (0)
`ifdef CMD_READROW_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .data_in          (data_in),
        .row              (row),
        .column           (column),
        .pixel            (pixel),
        .data_out         (data_out),
        .ram_write_enable (ram_write_enable),
        .ram_access_start (ram_access_start),
        .done             (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (ram_access_start !== ras_prev) toggle_cnt++;
        ras_prev = ram_access_start;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Each cycle without enable: everything holds, done stays low.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if ({row, column, pixel, data_out, ram_write_enable, ram_access_start, done} !==
                {exp_row, exp_col, exp_pix, exp_data, exp_we, exp_ras, 1'b0}) begin
                failures++;
                $display("FAIL idle_hold: got row=%0d col=%0d pix=%0d data=%h we=%b ras=%b done=%b, want row=%0d col=%0d pix=%0d data=%h we=%b ras=%b done=0",
                         row, column, pixel, data_out, ram_write_enable, ram_access_start, done,
                         exp_row, exp_col, exp_pix, exp_data, exp_we, exp_ras);
            end
        end
    endtask

    task automatic send_row(input logic [7:0] b);
        enable = 1'b1;
        data_in = b;
        @(negedge clk);
        enable = 1'b0;
        exp_row  = 5'(int'(b) % PH);
        exp_data = '0;
        exp_we   = 1'b0;
        checks++;
        if (row !== exp_row) begin
            failures++;
            $display("FAIL row_capture: got %0d want %0d (byte %h)", row, exp_row, b);
        end
        checks++;
        if ({ram_write_enable, data_out, done} !== {1'b0, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL row_quiet: got we=%b data=%h done=%b want we=0 data=00 done=0",
                     ram_write_enable, data_out, done);
        end
        $display("row select byte=%h row=%0d", b, row);
    endtask

    task automatic send_data(input int k, input logic [7:0] b);
        enable = 1'b1;
        data_in = b;
        @(negedge clk);
        enable = 1'b0;
        exp_data = b;
        exp_we   = 1'b1;
        exp_col  = 6'(PW - 1 - k / BPP);
        exp_pix  = 1'(BPP - 1 - k % BPP);
        exp_ras  = ~exp_ras;
        checks++;
        if ({data_out, ram_write_enable} !== {exp_data, 1'b1}) begin
            failures++;
            $display("FAIL write_data k=%0d: got data=%h we=%b want data=%h we=1",
                     k, data_out, ram_write_enable, exp_data);
        end
        checks++;
        if ({column, pixel} !== {exp_col, exp_pix}) begin
            failures++;
            $display("FAIL write_addr k=%0d: got col=%0d pix=%0d want col=%0d pix=%0d",
                     k, column, pixel, exp_col, exp_pix);
        end
        checks++;
        if (ram_access_start !== exp_ras) begin
            failures++;
            $display("FAIL access_toggle k=%0d: got %b want %b", k, ram_access_start, exp_ras);
        end
        checks++;
        if (done !== (k == NDATA - 1)) begin
            failures++;
            $display("FAIL done_flag k=%0d: got %b want %b", k, done, (k == NDATA - 1));
        end
        if (k < 3 || k == NDATA - 1)
            $display("write k=%0d data=%h col=%0d pix=%0d done=%b", k, data_out, column, pixel, done);
    endtask

    // Full row of data bytes; gap<0 picks a random 0..4 idle gap per byte.
    task automatic send_row_data(input int gap);
        for (int k = 0; k < NDATA; k++) begin
            send_data(k, 8'($urandom));
            if (k != NDATA - 1) idle(gap < 0 ? int'($urandom_range(0, 4)) : gap);
        end
    endtask

    task automatic check_tail(input int t0, input int d0, input int n_cmds);
        exp_we = 1'b0;
        exp_data = '0;
        idle(2);
        checks++;
        if (toggle_cnt - t0 !== NDATA * n_cmds) begin
            failures++;
            $display("FAIL toggle_count: got %0d want %0d", toggle_cnt - t0, NDATA * n_cmds);
        end
        checks++;
        if (done_cnt - d0 !== n_cmds) begin
            failures++;
            $display("FAIL done_count: got %0d want %0d", done_cnt - d0, n_cmds);
        end
        $display("command tail: toggles=%0d dones=%0d", toggle_cnt - t0, done_cnt - d0);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({row, column, pixel, data_out, ram_write_enable, ram_access_start, done} !== 23'd0) begin
            failures++;
            $display("FAIL reset_state: got row=%0d col=%0d pix=%0d data=%h we=%b ras=%b done=%b want all 0",
                     row, column, pixel, data_out, ram_write_enable, ram_access_start, done);
        end
        reset = 1'b1;
        idle(3);
        $display("reset released, outputs idle");
    endtask

    task automatic test_first_bytes;
        int t0, d0;
        t0 = toggle_cnt;
        d0 = done_cnt;
        send_row(8'h05);
        idle(2);
        send_data(0, 8'hA1);
        idle(15);
        send_data(1, 8'h3C);
        idle(15);
        send_data(2, 8'h7E);
        for (int k = 3; k < NDATA; k++) begin
            idle(15);
            send_data(k, 8'($urandom));
        end
        check_tail(t0, d0, 1);
    endtask

    task automatic test_random_rows;
        for (int c = 0; c < 2; c++) begin
            int t0, d0;
            t0 = toggle_cnt;
            d0 = done_cnt;
            send_row(8'($urandom));
            idle(int'($urandom_range(0, 3)));
            send_row_data(-1);
            check_tail(t0, d0, 1);
        end
    endtask

    // Second row byte arrives in the done cycle of the first command.
    task automatic test_back_to_back;
        int t0, d0;
        t0 = toggle_cnt;
        d0 = done_cnt;
        send_row(8'($urandom));
        send_row_data(0);
        send_row(8'($urandom | 32'h0000_00E0));
        send_row_data(-1);
        check_tail(t0, d0, 2);
    endtask

    task automatic test_reset_mid_command;
        int d0;
        d0 = done_cnt;
        send_row(8'($urandom));
        for (int k = 0; k < 10; k++) begin
            send_data(k, 8'($urandom));
            idle(int'($urandom_range(0, 2)));
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({row, column, pixel, data_out, ram_write_enable, ram_access_start, done} !== 23'd0) begin
            failures++;
            $display("FAIL abort_reset: got row=%0d col=%0d pix=%0d data=%h we=%b ras=%b done=%b want all 0",
                     row, column, pixel, data_out, ram_write_enable, ram_access_start, done);
        end
        exp_row = '0; exp_col = '0; exp_pix = '0; exp_data = '0; exp_we = 1'b0; exp_ras = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(3);
        checks++;
        if (done_cnt !== d0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt - d0);
        end
        $display("reset mid-command: outputs cleared, no done");
    endtask

    task automatic test_after_reset;
        int t0, d0;
        t0 = toggle_cnt;
        d0 = done_cnt;
        send_row(8'($urandom));
        send_row_data(-1);
        check_tail(t0, d0, 1);
    endtask

`ifdef CMD_READROW_TIMEOUT_EN
    task automatic test_timeout;
        int t0, d0;
        d0 = done_cnt;
        send_row(8'($urandom));
        for (int k = 0; k < 5; k++) send_data(k, 8'($urandom));
        repeat (101) @(negedge clk);
        exp_we = 1'b0;
        exp_data = '0;
        checks++;
        if ({ram_write_enable, data_out, done} !== 10'd0) begin
            failures++;
            $display("FAIL timeout_abort: got we=%b data=%h done=%b want 0", ram_write_enable, data_out, done);
        end
        checks++;
        if (done_cnt !== d0) begin
            failures++;
            $display("FAIL timeout_no_done: got %0d done pulses want 0", done_cnt - d0);
        end
        t0 = toggle_cnt;
        d0 = done_cnt;
        send_row(8'h0B);
        send_row_data(-1);
        check_tail(t0, d0, 1);
        $display("timeout abort then row 11 command completed");
    endtask
`endif

    initial begin
        test_reset;
        test_first_bytes;
        test_random_rows;
        test_back_to_back;
        test_reset_mid_command;
        test_after_reset;
`ifdef CMD_READROW_TIMEOUT_EN
        test_timeout;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
